// File: rtl/mac_result_fifo.sv
// ---------------------------------------------------------------------------
// MacResultFifo : post-processing and buffering of MAC accumulator results.
//
// Each valid 11-bit signed MAC result optionally passes through ReLU, is then
// saturated to 8-bit signed and pushed into a 4-entry first-word-fall-through
// FIFO. A sticky overflow flag records dropped results and a running peak
// tracks the maximum accepted value since reset or the last clear.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   asynchronous active-high reset
//   mac_in      in  11   signed MAC result
//   mac_valid   in   1   mac_in valid (one pulse per result)
//   relu_en     in   1   force negative results to zero
//   clear       in   1   synchronous clear of overflow and peak
//   out_data    out  8   signed head-of-FIFO value (0 when empty)
//   out_valid   out  1   FIFO non-empty
//   out_ready   in   1   consumer accepts head entry
//   fifo_count  out  3   occupancy 0..4
//   overflow    out  1   sticky: a result was dropped because FIFO was full
//   peak        out  8   signed maximum of accepted results
// ---------------------------------------------------------------------------
module mac_result_fifo (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] mac_in,
    input  logic        mac_valid,
    input  logic        relu_en,
    input  logic        clear,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  fifo_count,
    output logic        overflow,
    output logic [7:0]  peak
);

    localparam logic [2:0] DEPTH = 3'd4;

    logic        [7:0] mem_q [0:3];
    logic        [1:0] rdPtr_q, rdPtr_d;
    logic        [1:0] wrPtr_q, wrPtr_d;
    logic        [2:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic signed [7:0] peak_q, peak_d;

    logic signed [10:0] macSigned;
    logic signed [10:0] reluVal;
    logic signed [7:0]  satVal;
    logic               popEn;
    logic               pushEn;
    logic               dropEn;

    // ReLU followed by saturation of the 11-bit result into 8-bit signed.
    always_comb begin
        macSigned = mac_in;
        reluVal   = (relu_en && macSigned[10]) ? 11'sd0 : macSigned;
        if (reluVal > 11'sd127) begin
            satVal = 8'sd127;
        end else if (reluVal < -11'sd128) begin
            satVal = -8'sd128;
        end else begin
            satVal = reluVal[7:0];
        end
    end

    // A pop frees a slot in the same edge, so a full FIFO can still take a
    // push when the consumer is draining; only a push with no room is dropped.
    always_comb begin
        popEn  = (count_q != 3'd0) && out_ready;
        pushEn = mac_valid && ((count_q != DEPTH) || popEn);
        dropEn = mac_valid && (count_q == DEPTH) && !popEn;
    end

    // Next-state for pointers, occupancy, overflow and peak.
    always_comb begin
        rdPtr_d    = popEn  ? rdPtr_q + 2'd1 : rdPtr_q;
        wrPtr_d    = pushEn ? wrPtr_q + 2'd1 : wrPtr_q;
        count_d    = count_q + {2'b00, pushEn} - {2'b00, popEn};

        // A drop in the same cycle as clear wins, so no drop goes unreported.
        overflow_d = overflow_q;
        if (dropEn) begin
            overflow_d = 1'b1;
        end else if (clear) begin
            overflow_d = 1'b0;
        end

        // Clear restarts the maximum search; a push in that cycle seeds it.
        peak_d = peak_q;
        if (clear) begin
            peak_d = pushEn ? satVal : -8'sd128;
        end else if (pushEn && (satVal > peak_q)) begin
            peak_d = satVal;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q    <= 2'd0;
            wrPtr_q    <= 2'd0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
            peak_q     <= -8'sd128;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            peak_q     <= peak_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (!reset && pushEn) begin
            mem_q[wrPtr_q] <= satVal;
        end
    end

    assign out_valid  = (count_q != 3'd0);
    assign out_data   = out_valid ? mem_q[rdPtr_q] : 8'd0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign peak       = peak_q;

endmodule

// File: tb/tb_mac_result_fifo.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for mac_result_fifo. Inputs change 1 ns after
// each rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_mac_result_fifo;

    logic        clk;
    logic        reset;
    logic [10:0] mac_in;
    logic        mac_valid;
    logic        relu_en;
    logic        clear;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  peak;

    int checkCount = 0;
    int errorCount = 0;

    mac_result_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .mac_in     (mac_in),
        .mac_valid  (mac_valid),
        .relu_en    (relu_en),
        .clear      (clear),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .peak       (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, then return inputs to idle.
    task automatic applyStimulus(input logic mv, input logic [10:0] val,
                                 input logic relu, input logic rdy,
                                 input logic clr);
        mac_valid = mv;
        mac_in    = val;
        relu_en   = relu;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
        mac_valid = 1'b0;
        mac_in    = 11'd0;
        relu_en   = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    initial begin
        logic [7:0] drainExp [0:3];

        reset     = 1'b1;
        mac_in    = 11'd0;
        mac_valid = 1'b0;
        relu_en   = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("rst_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("rst_data", {8'd0, out_data}, 16'h0000);
        checkOutput("rst_count", {13'd0, fifo_count}, 16'd0);
        checkOutput("rst_ovf", {15'd0, overflow}, 16'd0);
        checkOutput("rst_peak", {8'd0, peak}, 16'h0080);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Saturation / ReLU with consumer always ready; first push is also
        // the empty push+pop case.
        applyStimulus(1'b1, 11'sd300, 1'b0, 1'b1, 1'b0);
        checkOutput("empty_valid", {15'd0, out_valid}, 16'd1);
        checkOutput("sat_hi", {8'd0, out_data}, 16'h007F);
        checkOutput("empty_count", {13'd0, fifo_count}, 16'd1);
        applyStimulus(1'b1, -11'sd500, 1'b0, 1'b1, 1'b0);
        checkOutput("sat_lo", {8'd0, out_data}, 16'h0080);
        checkOutput("sat_lo_count", {13'd0, fifo_count}, 16'd1);
        applyStimulus(1'b1, -11'sd5, 1'b1, 1'b1, 1'b0);
        checkOutput("relu", {8'd0, out_data}, 16'h0000);
        applyStimulus(1'b1, 11'sd42, 1'b0, 1'b1, 1'b0);
        checkOutput("pass42", {8'd0, out_data}, 16'h002A);
        applyStimulus(1'b0, 11'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("sat_drained", {15'd0, out_valid}, 16'd0);
        checkOutput("sat_empty_data", {8'd0, out_data}, 16'h0000);
        checkOutput("sat_peak", {8'd0, peak}, 16'h007F);
        applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_peak0", {8'd0, peak}, 16'h0080);

        // Overflow: five pushes into a stalled FIFO.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, 11'(i), 1'b0, 1'b0, 1'b0);
            if (i == 4) checkOutput("ovf_pre", {15'd0, overflow}, 16'd0);
        end
        checkOutput("ovf_count", {13'd0, fifo_count}, 16'd4);
        checkOutput("ovf_flag", {15'd0, overflow}, 16'd1);
        checkOutput("ovf_peak", {8'd0, peak}, 16'h0004);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("ovf_drain", {8'd0, out_data}, 16'(i));
            applyStimulus(1'b0, 11'd0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("ovf_empty", {15'd0, out_valid}, 16'd0);
        checkOutput("ovf_sticky", {15'd0, overflow}, 16'd1);

        // Full FIFO with push and pop in the same cycle.
        applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_ovf", {15'd0, overflow}, 16'd0);
        for (int i = 11; i <= 14; i++) begin
            applyStimulus(1'b1, 11'(i), 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 11'sd9, 1'b0, 1'b1, 1'b0);
        checkOutput("full_count", {13'd0, fifo_count}, 16'd4);
        checkOutput("full_ovf", {15'd0, overflow}, 16'd0);
        checkOutput("full_head", {8'd0, out_data}, 16'h000C);
        checkOutput("full_peak", {8'd0, peak}, 16'h000E);

        // Drop coinciding with clear: overflow must remain set.
        applyStimulus(1'b1, 11'sd50, 1'b0, 1'b0, 1'b1);
        checkOutput("dropclr_ovf", {15'd0, overflow}, 16'd1);
        checkOutput("dropclr_peak", {8'd0, peak}, 16'h0080);
        checkOutput("dropclr_count", {13'd0, fifo_count}, 16'd4);
        applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_only_ovf", {15'd0, overflow}, 16'd0);
        drainExp[0] = 8'd12;
        drainExp[1] = 8'd13;
        drainExp[2] = 8'd14;
        drainExp[3] = 8'd9;
        for (int i = 0; i < 4; i++) begin
            checkOutput("full_drain", {8'd0, out_data}, {8'd0, drainExp[i]});
            applyStimulus(1'b0, 11'd0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("full_empty", {15'd0, out_valid}, 16'd0);

        // Peak tracking and clear.
        applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 11'sd10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, -11'sd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'sd77, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'sd20, 1'b0, 1'b0, 1'b0);
        checkOutput("peak77", {8'd0, peak}, 16'h004D);
        applyStimulus(1'b0, 11'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("peak_clr", {8'd0, peak}, 16'h0080);
        checkOutput("peak_clr_ovf", {15'd0, overflow}, 16'd0);
        checkOutput("peak_clr_count", {13'd0, fifo_count}, 16'd4);
        checkOutput("peak_clr_head", {8'd0, out_data}, 16'h000A);
        applyStimulus(1'b1, 11'sd33, 1'b0, 1'b1, 1'b1);
        checkOutput("clr_push_peak", {8'd0, peak}, 16'h0021);
        checkOutput("clr_push_head", {8'd0, out_data}, 16'h00FD);
        applyStimulus(1'b0, 11'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_rst_count", {13'd0, fifo_count}, 16'd3);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("arst_count", {13'd0, fifo_count}, 16'd0);
        checkOutput("arst_data", {8'd0, out_data}, 16'h0000);
        checkOutput("arst_peak", {8'd0, peak}, 16'h0080);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 11'sd6, 1'b0, 1'b0, 1'b0);
        checkOutput("post_rst_head", {8'd0, out_data}, 16'h0006);
        checkOutput("post_rst_count", {13'd0, fifo_count}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mac_result_fifo.md
MAC_RESULT_FIFO -- requirements
Module: mac_result_fifo

Interface
REQ-001 SHALL have ports, one per line (name  direction  width  meaning):
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mac_in  input  11  signed accumulated result from the upstream MAC stage.
- mac_valid  input  1  mac_in valid; single-cycle pulse per result.
- relu_en  input  1  ReLU enable, sampled in the same cycle as mac_valid.
- clear  input  1  synchronous clear of overflow and peak.
- out_data  output  8  signed head-of-FIFO value.
- out_valid  output  1  FIFO non-empty; out_data meaningful.
- out_ready  input  1  consumer accepts out_data.
- fifo_count  output  3  entries held, 0..4.
- overflow  output  1  sticky flag; a result was dropped.
- peak  output  8  signed maximum of accepted results since reset/clear.

Function
REQ-002 SHALL process a result in the cycle where mac_valid=1:
- r = (relu_en && mac_in<0) ? 0 : mac_in;
- s = clamp(r, -128, +127), giving 8-bit signed.
REQ-003 SHALL write s into a 4-entry FIFO at the same rising edge where mac_valid is sampled high (push latency 1 cycle to visibility).
REQ-004 SHALL be first-word-fall-through:
- out_valid = (fifo_count != 0);
- out_data = entry at read pointer when non-empty, 0 when empty.
REQ-005 SHALL pop one entry on each rising edge where out_valid && out_ready; out_ready while empty has no effect.
REQ-006 SHALL use 2-bit read/write pointers that wrap 3->0; fifo_count tracks occupancy 0..4 exactly.
REQ-007 Push and pop in the same cycle, non-empty: both SHALL occur, fifo_count unchanged, order preserved.
REQ-008 Push when fifo_count=4 with a pop in the same cycle SHALL be accepted; count stays 4; no overflow.
REQ-009 Push when fifo_count=4 without a pop SHALL be dropped: FIFO unchanged, overflow set to 1 at that edge.
REQ-010 Push and pop while empty: the new value SHALL be stored; the pop is ignored (out_valid was 0).
REQ-011 overflow SHALL stay 1 until reset, or until clear=1 in a cycle with no new drop; a drop in the same cycle as clear SHALL leave overflow=1.
REQ-012 peak SHALL update at each accepted push to max(peak, s); dropped results SHALL NOT affect peak.
REQ-013 clear=1 SHALL set peak to -128; an accepted push in the same cycle SHALL set peak to s.
REQ-014 clear SHALL NOT alter FIFO contents, pointers or fifo_count.
REQ-015 All outputs SHALL be driven from registers or from the FIFO memory and count only; no combinational path from out_ready or mac_valid to any output.

Reset
REQ-016 On reset=1, asynchronously and without waiting for clk: out_valid=0, out_data=0, fifo_count=0, overflow=0, peak=-128 (8'h80), pointers 0.
REQ-017 Reset mid-operation SHALL discard all FIFO contents; the first push after release becomes the head.
REQ-018 While reset=1, mac_valid, out_ready and clear SHALL be ignored.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Saturation/ReLU: push 300, -500, -5 (relu_en=1), 42 with out_ready=1 -> out_data sequence 127, -128, 0, 42.
- Overflow: out_ready=0, push 1,2,3,4,5 -> fifo_count=4, overflow=1 after the 5th; drain -> 1,2,3,4, then out_valid=0.
- Full with simultaneous traffic: fifo_count=4, push 9 with out_ready=1 -> head pops, count stays 4, overflow stays 0, 9 emerges last.
- Peak and clear: push 10, -3, 77, 20 -> peak=77; pulse clear -> peak=-128, overflow=0, fifo_count unchanged.
- Async reset: fifo_count=3, assert reset between edges -> out_valid=0, fifo_count=0, out_data=0 immediately; push 6 after release -> out_data=6.
- Empty edge case: push 7 with out_ready=1 while empty -> next cycle out_valid=1, out_data=7, fifo_count=1.
